// File: rtl/reorder_buffer_pkg.sv
// Shared CPU definitions: register width, entry type encodings, ROB entry layout.
package reorder_buffer_pkg;

    localparam int unsigned REG_WIDTH = 32;
    localparam int unsigned RD_WIDTH  = 5;

    typedef enum logic [1:0] {
        ENTRY_REG    = 2'd0,
        ENTRY_BRANCH = 2'd1,
        ENTRY_STORE  = 2'd2
    } entry_type_e;

    typedef struct packed {
        entry_type_e          typ;
        logic [RD_WIDTH-1:0]  rd;
        logic [REG_WIDTH-1:0] value;
        logic                 ready;
        logic                 mispredict;
        logic [REG_WIDTH-1:0] target;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of out-of-order results, with
// branch-misprediction flush and operand forwarding from the write-back bus.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_signal,
    input  logic [1:0]           issue_type,
    input  logic [RD_WIDTH-1:0]  issue_rd,
    output logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 rob_full,
    input  logic [ROB_WIDTH-1:0] query_tag_1,
    input  logic [ROB_WIDTH-1:0] query_tag_2,
    output logic                 query_ready_1,
    output logic                 query_ready_2,
    output logic [REG_WIDTH-1:0] query_value_1,
    output logic [REG_WIDTH-1:0] query_value_2,
    input  logic                 wb_signal,
    input  logic [ROB_WIDTH-1:0] wb_tag,
    input  logic [REG_WIDTH-1:0] wb_value,
    input  logic                 wb_mispredict,
    input  logic [REG_WIDTH-1:0] wb_target,
    output logic                 commit_signal,
    output logic [REG_WIDTH-1:0] commit_rd_value,
    output logic [ROB_WIDTH-1:0] commit_rd_tag,
    output logic                 commit_store_signal,
    output logic [ROB_WIDTH-1:0] commit_store_tag,
    output logic                 clear_signal,
    output logic [REG_WIDTH-1:0] clear_pc
);

    localparam int unsigned DEPTH = 1 << ROB_WIDTH;
    localparam int unsigned CNT_W = ROB_WIDTH + 1;

    rob_entry_t           r_entries [DEPTH];
    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [CNT_W-1:0]     r_count;

    logic                 w_issue_fire;
    logic                 w_wb_fire;
    logic                 w_commit_fire;
    logic                 w_flush;
    logic [CNT_W-1:0]     w_count_next;

    assign issue_tag = r_tail;
    assign rob_full  = (r_count == CNT_W'(DEPTH));

    // Qualify each event; the cycle after a flush discards all activity.
    assign w_issue_fire  = rdy_in & issue_signal & ~rob_full & ~clear_signal;
    assign w_wb_fire     = rdy_in & wb_signal & ~clear_signal;
    assign w_commit_fire = rdy_in & ~clear_signal & (r_count != '0) & r_entries[r_head].ready;
    assign w_flush       = w_commit_fire & (r_entries[r_head].typ == ENTRY_BRANCH)
                         & r_entries[r_head].mispredict;

    // Occupancy update; simultaneous issue and commit cancel out.
    always_comb begin
        w_count_next = r_count;
        if (w_issue_fire && !w_commit_fire) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_issue_fire && w_commit_fire) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // Operand lookup with bypass of the result currently on the write-back bus.
    always_comb begin
        query_ready_1 = r_entries[query_tag_1].ready;
        query_value_1 = r_entries[query_tag_1].value;
        query_ready_2 = r_entries[query_tag_2].ready;
        query_value_2 = r_entries[query_tag_2].value;
        if (wb_signal && (wb_tag == query_tag_1)) begin
            query_ready_1 = 1'b1;
            query_value_1 = wb_value;
        end
        if (wb_signal && (wb_tag == query_tag_2)) begin
            query_ready_2 = 1'b1;
            query_value_2 = wb_value;
        end
        // Reset forces every output low even while the bus is active.
        if (!rst_in) begin
            query_ready_1 = 1'b0;
            query_value_1 = '0;
            query_ready_2 = 1'b0;
            query_value_2 = '0;
        end
    end

    // Entry array, pointers, and registered commit/flush strobes.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entries[ROB_WIDTH'(i)] <= '0;
            end
            r_head              <= '0;
            r_tail              <= '0;
            r_count             <= '0;
            commit_signal       <= 1'b0;
            commit_rd_value     <= '0;
            commit_rd_tag       <= '0;
            commit_store_signal <= 1'b0;
            commit_store_tag    <= '0;
            clear_signal        <= 1'b0;
            clear_pc            <= '0;
        end else if (rdy_in) begin
            commit_signal       <= 1'b0;
            commit_store_signal <= 1'b0;
            clear_signal        <= 1'b0;

            if (w_issue_fire) begin
                r_entries[r_tail].typ        <= entry_type_e'(issue_type);
                r_entries[r_tail].rd         <= issue_rd;
                r_entries[r_tail].value      <= '0;
                r_entries[r_tail].ready      <= (issue_type == 2'(ENTRY_STORE));
                r_entries[r_tail].mispredict <= 1'b0;
                r_entries[r_tail].target     <= '0;
            end

            if (w_wb_fire) begin
                r_entries[wb_tag].value      <= wb_value;
                r_entries[wb_tag].ready      <= 1'b1;
                r_entries[wb_tag].mispredict <= wb_mispredict;
                r_entries[wb_tag].target     <= wb_target;
            end

            if (w_commit_fire) begin
                case (r_entries[r_head].typ)
                    ENTRY_REG: begin
                        commit_signal   <= 1'b1;
                        commit_rd_value <= r_entries[r_head].value;
                        commit_rd_tag   <= r_head;
                    end
                    ENTRY_STORE: begin
                        commit_store_signal <= 1'b1;
                        commit_store_tag    <= r_head;
                    end
                    default: ;
                endcase
            end

            if (w_flush) begin
                r_head       <= '0;
                r_tail       <= '0;
                r_count      <= '0;
                clear_signal <= 1'b1;
                clear_pc     <= r_entries[r_head].target;
            end else begin
                if (w_commit_fire) r_head <= r_head + ROB_WIDTH'(1);
                if (w_issue_fire)  r_tail <= r_tail + ROB_WIDTH'(1);
                r_count <= w_count_next;
            end
        end
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, tag width; depth = 2^ROB_WIDTH entries (16).
REQ-002 SHALL have ports, in order:
- clk_in  in  1  system clock; the single clock.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  ready; when low, all state holds and registered outputs hold.
- issue_signal  in  1  allocate one entry this cycle.
- issue_type  in  2  0=REG write, 1=BRANCH, 2=STORE.
- issue_rd  in  5  destination register id.
- issue_tag  out  ROB_WIDTH  tag allocated on issue (current tail).
- rob_full  out  1  no free entry.
- query_tag_1, query_tag_2  in  ROB_WIDTH  operand tags from the register file.
- query_ready_1, query_ready_2  out  1  entry holds its result.
- query_value_1, query_value_2  out  32  result of the queried entry.
- wb_signal  in  1  result broadcast.
- wb_tag  in  ROB_WIDTH  producing entry.
- wb_value  in  32  result value.
- wb_mispredict  in  1  branch resolved against its prediction.
- wb_target  in  32  correct PC for a mispredicted branch.
- commit_signal  out  1  register commit strobe to the register file.
- commit_rd_value  out  32  committed value.
- commit_rd_tag  out  ROB_WIDTH  committed entry tag.
- commit_store_signal  out  1  head store may be performed.
- commit_store_tag  out  ROB_WIDTH  tag of that store.
- clear_signal  out  1  flush on misprediction.
- clear_pc  out  32  redirect PC.

Function
REQ-003 SHALL keep a circular buffer with head, tail and a count of 0..2^ROB_WIDTH; each entry SHALL hold type, rd, value, ready, mispredict and target.
REQ-004 SHALL drive issue_tag = tail combinationally, and rob_full = (count == 2^ROB_WIDTH) from registered count only.
REQ-005 On an edge with rdy_in & issue_signal & ~rob_full & ~clear_signal, SHALL write the entry at tail with ready=0 (ready=1 for STORE), then increment tail modulo depth.
REQ-006 Issue while rob_full is asserted SHALL be ignored; the issuer is responsible for stalling.
REQ-007 On an edge with rdy_in & wb_signal & ~clear_signal, SHALL set value, ready, mispredict and target of entry wb_tag.
REQ-008 query_ready_x/query_value_x SHALL be combinational and SHALL forward wb_value when wb_signal and wb_tag == query_tag_x.
REQ-009 At most one commit per cycle: when count>0 and the head entry is ready at an edge (with rdy_in & ~clear_signal), SHALL retire the head and increment head.
REQ-010 Commit outputs SHALL be registered pulses of one cycle:
- REG type: commit_signal=1, with value and tag of the head entry.
- STORE type: commit_store_signal=1 and commit_store_tag.
- BRANCH type: neither strobe.
REQ-011 A retiring BRANCH with mispredict=1 SHALL assert clear_signal for one cycle, set clear_pc = target, and set head=tail=count=0 on that same edge.
REQ-012 While clear_signal is high, issue and wb inputs SHALL be ignored and no commit SHALL occur.
REQ-013 On an edge with both issue and commit, count SHALL be unchanged.
REQ-014 A write-back to the head entry SHALL commit no earlier than the next edge; there is no same-cycle commit.
REQ-015 head and tail SHALL wrap from 2^ROB_WIDTH-1 to 0.

Reset
REQ-016 On rst_in low, asynchronously: head=tail=count=0, all entry ready=0, all outputs 0; rst_in SHALL override an in-progress flush or commit.

Structure
REQ-017 Entry type encodings and the REG_WIDTH=32 constant SHALL live in the shared CPU package.
REQ-018 No sub-module is required; the entry array SHALL be inline registers.

Verification
REQ-019 Issue REG rd=5 (tag 0), wb tag0 value 0x1234 -> next cycle commit_signal=1, tag=0, value=0x1234, count=0.
REQ-020 Issue 16 entries without wb -> rob_full=1; a 17th issue is ignored and tail=0.
REQ-021 Issue BRANCH tag0 and REG tag1; wb tag1 first, then tag0 with mispredict, target 0x80 -> tag0 retires, clear_signal=1, clear_pc=0x80, tag1 never commits, count=0.
REQ-022 query_tag_1=3 while wb_signal with wb_tag=3, value 0xAA -> query_ready_1=1, query_value_1=0xAA in the same cycle.
REQ-023 Hold rdy_in=0 across a ready head -> no commit; commit on the first cycle after rdy_in returns high.
REQ-024 Pull rst_in low mid-stream with 5 entries -> all outputs 0 immediately, before the next edge.
